si_cmd_ctrl: RTL and testbench

Command controller on the FT245 simple-interface (SI) byte streams: it consumes command bytes from the rx SI side of `ft245_block` and decodes register write/read commands. It maintains a bank of 16-bit control registers and returns read data on the tx SI side. It sits between `ft245_block` and the acquisition/trigger logic in the board top, driven by the 100 MHz PLL clock, and replaces the loopback wiring with a register protocol.

---
 rtl/si_cmd_ctrl.sv | 146 ++++++++++++++
 tb/tb_si_cmd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/si_cmd_ctrl.sv
// Register command controller on the FT245 simple-interface byte streams.
// Decodes 3-byte writes and 1-byte reads into a bank of 16-bit registers.
module si_cmd_ctrl #(
  parameter int REG_COUNT      = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data_si,
  input  logic                     rx_rdy_si,
  output logic                     rx_ack_si,
  output logic [7:0]               tx_data_si,
  output logic                     tx_rdy_si,
  input  logic                     tx_ack_si,
  output logic [16*REG_COUNT-1:0]  regs_o,
  output logic [REG_COUNT-1:0]     wr_strobe_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, COMMIT, SEND_HI, SEND_LO} state_e;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                 state_q;
  logic                   rx_ack_q;
  logic [6:0]             addr_q;
  logic [7:0]             hi_q;
  logic [7:0]             rd_lo_q;
  logic [7:0]             tx_data_q;
  logic                   tx_rdy_q;
  logic [TW-1:0]          tmo_q;
  logic [15:0]            regs_q [REG_COUNT];
  logic [REG_COUNT-1:0]   wr_strobe_q;
  logic                   err_q;

  logic                   rx_take_d;
  logic [15:0]            rd_word_d;
  logic                   op_in_range_d;
  logic                   addr_in_range_d;

  always_comb begin
    rx_take_d       = rx_rdy_si && !rx_ack_q &&
                      ((state_q == IDLE) || (state_q == GET_HI) || (state_q == GET_LO));
    op_in_range_d   = int'(rx_data_si[6:0]) < REG_COUNT;
    addr_in_range_d = int'(addr_q) < REG_COUNT;
    // Out-of-range addresses match no register and read back as zero.
    rd_word_d = '0;
    for (int k = 0; k < REG_COUNT; k++) begin
      if (rx_data_si[6:0] == 7'(k)) rd_word_d = regs_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_ack_q    <= 1'b0;
      addr_q      <= '0;
      hi_q        <= '0;
      rd_lo_q     <= '0;
      tx_data_q   <= '0;
      tx_rdy_q    <= 1'b0;
      tmo_q       <= '0;
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < REG_COUNT; k++) regs_q[k] <= '0;
    end else begin
      rx_ack_q    <= rx_take_d;
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (rx_take_d) begin
            addr_q <= rx_data_si[6:0];
            if (rx_data_si[7]) begin
              state_q <= GET_HI;
            end else begin
              tx_data_q <= rd_word_d[15:8];
              rd_lo_q   <= rd_word_d[7:0];
              tx_rdy_q  <= 1'b1;
              err_q     <= !op_in_range_d;
              state_q   <= SEND_HI;
            end
          end
        end
        GET_HI, GET_LO: begin
          if (rx_take_d) begin
            tmo_q <= '0;
            if (state_q == GET_HI) begin
              hi_q    <= rx_data_si;
              state_q <= GET_LO;
            end else begin
              // Update lands at the LSB edge so it is visible during COMMIT.
              for (int k = 0; k < REG_COUNT; k++) begin
                if (addr_q == 7'(k)) begin
                  regs_q[k]      <= {hi_q, rx_data_si};
                  wr_strobe_q[k] <= 1'b1;
                end
              end
              err_q   <= !addr_in_range_d;
              state_q <= COMMIT;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tmo_q == TMO_LAST) begin
              tmo_q   <= '0;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        COMMIT: state_q <= IDLE;
        SEND_HI: begin
          if (tx_ack_si) begin
            tx_rdy_q <= 1'b0;
            state_q  <= SEND_LO;
          end
        end
        SEND_LO: begin
          // First cycle here is the mandatory low gap between the two bytes.
          if (!tx_rdy_q) begin
            tx_rdy_q  <= 1'b1;
            tx_data_q <= rd_lo_q;
          end else if (tx_ack_si) begin
            tx_rdy_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_ack_si   = rx_ack_q;
  assign tx_data_si  = tx_data_q;
  assign tx_rdy_si   = tx_rdy_q;
  assign wr_strobe_o = wr_strobe_q;
  assign err_o       = err_q;

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs
    assign regs_o[16*g +: 16] = regs_q[g];
  end

endmodule

// File: tb/tb_si_cmd_ctrl.sv
// Self-checking bench for si_cmd_ctrl: directed scenarios plus random commands
// checked against a simple register-array model.
module tb_si_cmd_ctrl;

  localparam int NREG = 8;
  localparam int TMO  = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              rx_ack_si;
  logic [7:0]        tx_data_si;
  logic              tx_rdy_si;
  logic              tx_ack;
  logic [16*NREG-1:0] regs_o;
  logic [NREG-1:0]   wr_strobe_o;
  logic              err_o;

  int tests = 0;
  int fails = 0;
  int ack_cnt = 0, err_cnt = 0, strobe_cnt = 0, ack_double = 0;
  logic prev_ack = 1'b0;
  logic [15:0] model_regs [NREG];

  si_cmd_ctrl #(.REG_COUNT(NREG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data_si(rx_data), .rx_rdy_si(rx_rdy), .rx_ack_si(rx_ack_si),
    .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack),
    .regs_o(regs_o), .wr_strobe_o(wr_strobe_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters observed mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
    end else begin
      if (rx_ack_si) ack_cnt++;
      if (err_o) err_cnt++;
      if (wr_strobe_o != '0) strobe_cnt++;
      if (rx_ack_si && prev_ack) ack_double++;
      prev_ack = rx_ack_si;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [16*NREG-1:0] model_vec();
    logic [16*NREG-1:0] v;
    for (int k = 0; k < NREG; k++) v[16*k +: 16] = model_regs[k];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input string name);
    int n = 0;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!rx_ack_si && n < 50);
    rx_rdy = 1'b0;
    tests++;
    if (rx_ack_si !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s byte %02h: rx_ack_si=%b want 1 within 50 cycles", name, b, rx_ack_si);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [15:0] d, input int gap, input string name);
    int a0 = ack_cnt, e0 = err_cnt, s0 = strobe_cnt;
    logic in_range = (a < 7'(NREG));
    logic [NREG-1:0] exp_strobe = in_range ? (NREG'(1) << a) : '0;
    send_byte({1'b1, a}, name);
    repeat (gap) @(posedge clk);
    send_byte(d[15:8], name);
    repeat (gap) @(posedge clk);
    send_byte(d[7:0], name);
    if (in_range) model_regs[a] = d;
    tests++;
    if (regs_o !== model_vec() || wr_strobe_o !== exp_strobe || err_o !== !in_range) begin
      fails++;
      $display("[TB] FAIL %s commit: regs=%h strobe=%b err=%b want regs=%h strobe=%b err=%b",
               name, regs_o, wr_strobe_o, err_o, model_vec(), exp_strobe, !in_range);
    end
    @(posedge clk); #1;
    tests++;
    if (wr_strobe_o !== '0 || err_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s pulse width: strobe=%b err=%b want 0 0", name, wr_strobe_o, err_o);
    end
    tests++;
    if (ack_cnt - a0 != 3 || err_cnt - e0 != int'(!in_range) || strobe_cnt - s0 != int'(in_range)) begin
      fails++;
      $display("[TB] FAIL %s pulse counts: acks=%0d errs=%0d strobes=%0d want 3 %0d %0d",
               name, ack_cnt - a0, err_cnt - e0, strobe_cnt - s0, int'(!in_range), int'(in_range));
    end
  endtask

  task automatic hold_and_ack(input logic [7:0] exp, input int delay, input string name);
    logic unstable = 1'b0;
    repeat (delay) begin
      @(negedge clk);
      if (tx_rdy_si !== 1'b1 || tx_data_si !== exp) unstable = 1'b1;
    end
    tests++;
    if (unstable) begin
      fails++;
      $display("[TB] FAIL %s hold: tx_rdy=%b data=%02h want stable 1 %02h", name, tx_rdy_si, tx_data_si, exp);
    end
    @(negedge clk);
    tx_ack = 1'b1;
    @(posedge clk); #1;
    tx_ack = 1'b0;
    tests++;
    if (tx_rdy_si !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s drop after ack: tx_rdy=%b want 0", name, tx_rdy_si);
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int delay, input string name);
    int e0 = err_cnt;
    logic in_range = (a < 7'(NREG));
    logic [15:0] exp = in_range ? model_regs[a] : 16'h0000;
    send_byte({1'b0, a}, name);
    tests++;
    if (tx_rdy_si !== 1'b1 || tx_data_si !== exp[15:8] || err_o !== !in_range) begin
      fails++;
      $display("[TB] FAIL %s msb: rdy=%b data=%02h err=%b want 1 %02h %b",
               name, tx_rdy_si, tx_data_si, err_o, exp[15:8], !in_range);
    end
    hold_and_ack(exp[15:8], delay, name);
    @(posedge clk); #1;
    tests++;
    if (tx_rdy_si !== 1'b1 || tx_data_si !== exp[7:0]) begin
      fails++;
      $display("[TB] FAIL %s lsb: rdy=%b data=%02h want 1 %02h", name, tx_rdy_si, tx_data_si, exp[7:0]);
    end
    hold_and_ack(exp[7:0], delay, name);
    @(posedge clk); #1;
    tests++;
    if (tx_rdy_si !== 1'b0 || err_cnt - e0 != int'(!in_range)) begin
      fails++;
      $display("[TB] FAIL %s end: rdy=%b errs=%0d want 0 %0d", name, tx_rdy_si, err_cnt - e0, int'(!in_range));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rx_ack_si !== 1'b0 || tx_rdy_si !== 1'b0 || tx_data_si !== 8'h00 ||
        regs_o !== '0 || wr_strobe_o !== '0 || err_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset: ack=%b rdy=%b data=%02h regs=%h strobe=%b err=%b want all 0",
               rx_ack_si, tx_rdy_si, tx_data_si, regs_o, wr_strobe_o, err_o);
    end
    rst = 1'b0;
    for (int k = 0; k < NREG; k++) model_regs[k] = '0;
  endtask

  task automatic test_write_read();
    do_write(7'h03, 16'h1234, 0, "write_reg3");
    do_read(7'h03, 5, "read_reg3_slow");
  endtask

  task automatic test_bad_addr();
    do_write(7'h7F, 16'hAA55, 1, "write_bad");
    do_read(7'h7F, 0, "read_bad");
    do_read(7'h03, 0, "read_reg3_after_bad");
  endtask

  task automatic test_timeout();
    int e0;
    int bad = 0;
    send_byte(8'h81, "timeout_op");
    e0 = err_cnt;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (err_o !== (i == TMO)) bad++;
    end
    tests++;
    if (bad != 0 || err_cnt - e0 != 1) begin
      fails++;
      $display("[TB] FAIL timeout: wrong-cycles=%0d errs=%0d want 0 1", bad, err_cnt - e0);
    end
    do_write(7'h01, 16'hBEEF, 0, "write_after_timeout");
  endtask

  task automatic test_reset_mid_read();
    do_write(7'h05, 16'h5A5A, 0, "write_reg5");
    send_byte(8'h05, "read_reg5_op");
    tests++;
    if (tx_rdy_si !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reset pre: tx_rdy=%b want 1", tx_rdy_si);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (tx_rdy_si !== 1'b0 || regs_o !== '0 || rx_ack_si !== 1'b0 || err_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset: rdy=%b regs=%h ack=%b err=%b want 0 0 0 0",
               tx_rdy_si, regs_o, rx_ack_si, err_o);
    end
    rst = 1'b0;
    for (int k = 0; k < NREG; k++) model_regs[k] = '0;
    do_write(7'h02, 16'hCAFE, 0, "write_after_reset");
    do_read(7'h02, 1, "read_after_reset");
    do_read(7'h05, 0, "read_cleared_reg5");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] a = 7'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) a = 7'h7F;
      if ($urandom_range(0, 1) == 1)
        do_write(a, 16'($urandom), int'($urandom_range(0, 4)), "rand_write");
      else
        do_read(a, int'($urandom_range(0, 3)), "rand_read");
    end
  endtask

  task automatic test_back_to_back();
    do_write(7'h00, 16'h0F0F, 0, "b2b_w0");
    do_write(7'h07, 16'hF00D, 0, "b2b_w7");
    do_read(7'h00, 0, "b2b_r0");
    do_read(7'h07, 0, "b2b_r7");
    tests++;
    if (ack_double != 0) begin
      fails++;
      $display("[TB] FAIL ack_spacing: back-to-back acks=%0d want 0", ack_double);
    end
  endtask

  initial begin
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_rdy  = 1'b0;
    tx_ack  = 1'b0;
    test_reset();
    test_write_read();
    test_bad_addr();
    test_timeout();
    test_reset_mid_read();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
